// File: rtl/psum_accumulator.sv
// Accumulates groups of PE-row partial sums, then rounds, shifts, optionally ReLUs
// and saturates each group total into a small valid/ready output FIFO.
module psum_accumulator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ACC_W = 2 * WIDTH + 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [2*WIDTH-1:0]   i_psum,
  input  logic                 i_clear,
  input  logic [7:0]           cfg_len,
  input  logic [4:0]           cfg_shift,
  input  logic                 cfg_relu,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  input  logic                 o_ready,
  output logic                 o_stall,
  output logic                 o_busy,
  output logic                 o_ovf
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned RND_W = ACC_W + 1;
  localparam logic signed [RND_W-1:0] SAT_MAX = RND_W'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [7:0]              cnt_q, cnt_d, len_q, len_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [4:0]              shift_q, shift_d;
  logic                    relu_q, relu_d;
  logic                    q_valid_q, q_valid_d;
  logic signed [ACC_W-1:0] q_sum_q, q_sum_d;
  logic [4:0]              q_shift_q, q_shift_d;
  logic                    q_relu_q, q_relu_d;

  logic [WIDTH-1:0]        mem_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    ovf_q;

  logic                    first;
  logic [7:0]              eff_len;
  logic [4:0]              eff_shift;
  logic                    eff_relu;
  logic signed [ACC_W-1:0] psum_ext, sum;

  logic signed [RND_W-1:0] rnd_add, rnd_sum, shifted;
  logic [WIDTH-1:0]        q_data;
  logic                    pop, push, full, drop;

  // Stage A: group accumulation; cfg is taken only on the first psum of a group
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    len_d     = len_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    q_valid_d = 1'b0;
    q_sum_d   = q_sum_q;
    q_shift_d = q_shift_q;
    q_relu_d  = q_relu_q;
    first     = (cnt_q == 8'd0);
    eff_len   = first ? ((cfg_len == 8'd0) ? 8'd1 : cfg_len) : len_q;
    eff_shift = first ? cfg_shift : shift_q;
    eff_relu  = first ? cfg_relu : relu_q;
    psum_ext  = ACC_W'($signed(i_psum));
    sum       = (first ? '0 : acc_q) + psum_ext;
    if (i_clear) begin
      cnt_d = 8'd0;
      acc_d = '0;
    end else if (i_valid) begin
      len_d   = eff_len;
      shift_d = eff_shift;
      relu_d  = eff_relu;
      if (8'(cnt_q + 8'd1) == eff_len) begin
        cnt_d     = 8'd0;
        acc_d     = '0;
        q_valid_d = 1'b1;
        q_sum_d   = sum;
        q_shift_d = eff_shift;
        q_relu_d  = eff_relu;
      end else begin
        cnt_d = 8'(cnt_q + 8'd1);
        acc_d = sum;
      end
    end
  end

  // Stage B: half-up rounding shift, optional ReLU, saturation to WIDTH bits
  always_comb begin
    rnd_add = '0;
    if (q_shift_q != 5'd0) rnd_add = RND_W'(1) << (q_shift_q - 5'd1);
    rnd_sum = RND_W'(q_sum_q) + rnd_add;
    shifted = rnd_sum >>> q_shift_q;
    if (q_relu_q && shifted[RND_W-1]) shifted = '0;
    if (shifted > SAT_MAX)      q_data = SAT_MAX[WIDTH-1:0];
    else if (shifted < SAT_MIN) q_data = SAT_MIN[WIDTH-1:0];
    else                        q_data = shifted[WIDTH-1:0];
  end

  // FIFO control: a same-cycle pop frees the slot for a push even when full
  always_comb begin
    full  = (count_q == CNT_W'(DEPTH));
    pop   = (count_q != '0) && o_ready;
    push  = q_valid_q && (!full || pop);
    drop  = q_valid_q && full && !pop;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= 8'd0;
      acc_q     <= '0;
      len_q     <= 8'd1;
      shift_q   <= 5'd0;
      relu_q    <= 1'b0;
      q_valid_q <= 1'b0;
      q_sum_q   <= '0;
      q_shift_q <= 5'd0;
      q_relu_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      len_q     <= len_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      q_valid_q <= q_valid_d;
      q_sum_q   <= q_sum_d;
      q_shift_q <= q_shift_d;
      q_relu_q  <= q_relu_d;
      count_q   <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= q_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (drop) ovf_q <= 1'b1;
    end
  end

  assign o_valid = (count_q != '0);
  assign o_data  = mem_q[rd_ptr_q];
  assign o_busy  = (cnt_q != 8'd0);
  assign o_ovf   = ovf_q;
  assign o_stall = ((CNT_W + 1)'(count_q) + (CNT_W + 1)'(q_valid_q)) >= (CNT_W + 1)'(DEPTH - 1);

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench for psum_accumulator: vector table plus hand sequences,
// with a scoreboard queue compared against every FIFO pop.
module tb_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [15:0] i_psum;
  logic        i_clear;
  logic [7:0]  cfg_len;
  logic [4:0]  cfg_shift;
  logic        cfg_relu;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_ready;
  logic        o_stall;
  logic        o_busy;
  logic        o_ovf;

  int checks = 0;
  int fails  = 0;
  int sb [$];

  typedef struct {
    logic [7:0] len;
    logic [4:0] shift;
    logic       relu;
    int         psum;
    int         exp;
  } vec_t;

  vec_t vecs [13];

  psum_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .i_psum   (i_psum),
    .i_clear  (i_clear),
    .cfg_len  (cfg_len),
    .cfg_shift(cfg_shift),
    .cfg_relu (cfg_relu),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_ready  (o_ready),
    .o_stall  (o_stall),
    .o_busy   (o_busy),
    .o_ovf    (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Scoreboard compare at negedge, then advance past the next rising edge
  task automatic tick();
    int e;
    @(negedge clk);
    if (o_valid && o_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected: got %0d expected no output", int'($signed(o_data)));
      end else begin
        e = sb.pop_front();
        check("sb_data", int'($signed(o_data)), e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    o_ready = 1'b1;
    for (int n = 0; n < 40 && sb.size() != 0; n++) tick();
    check("drain_left", sb.size(), 0);
  endtask

  task automatic send(input int p);
    i_valid = 1'b1;
    i_psum  = 16'(p);
    tick();
    i_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(o_valid), 0);
    check({tag, "_data"},  int'(o_data),  0);
    check({tag, "_stall"}, int'(o_stall), 0);
    check({tag, "_busy"},  int'(o_busy),  0);
    check({tag, "_ovf"},   int'(o_ovf),   0);
  endtask

  // len=4 sum of 1..4 with latency and busy-window checks
  task automatic basic_group();
    cfg_len = 8'd4; cfg_shift = 5'd0; cfg_relu = 1'b0; o_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      i_valid = 1'b1;
      i_psum  = 16'(i);
      if (i == 4) sb.push_back(10);
      tick();
      check("basic_busy", int'(o_busy), (i < 4) ? 1 : 0);
    end
    i_valid = 1'b0;
    check("basic_valid_k", int'(o_valid), 0);
    tick();
    check("basic_valid_k1", int'(o_valid), 1);
    check("basic_data_k1", int'($signed(o_data)), 10);
    drain();
  endtask

  initial begin
    int stall_exp [5];
    stall_exp = '{0, 0, 1, 1, 1};
    vecs[0]  = '{8'd1, 5'd0, 1'b0,    300,  127};
    vecs[1]  = '{8'd1, 5'd0, 1'b0,   -300, -128};
    vecs[2]  = '{8'd1, 5'd0, 1'b1,     -5,    0};
    vecs[3]  = '{8'd1, 5'd0, 1'b1,      5,    5};
    vecs[4]  = '{8'd0, 5'd0, 1'b0,      3,    3};
    vecs[5]  = '{8'd1, 5'd4, 1'b0,   1000,   63};
    vecs[6]  = '{8'd1, 5'd4, 1'b0,  -1000,  -62};
    vecs[7]  = '{8'd1, 5'd8, 1'b0,  32767,  127};
    vecs[8]  = '{8'd1, 5'd8, 1'b0, -32768, -128};
    vecs[9]  = '{8'd1, 5'd1, 1'b0,     -3,   -1};
    vecs[10] = '{8'd1, 5'd0, 1'b1, -32768,    0};
    vecs[11] = '{8'd1, 5'd1, 1'b1,      3,    2};
    vecs[12] = '{8'd1, 5'd0, 1'b1,    200,  127};

    rst = 1'b1; i_valid = 1'b0; i_psum = '0; i_clear = 1'b0;
    cfg_len = 8'd1; cfg_shift = 5'd0; cfg_relu = 1'b0; o_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    basic_group();

    // Single-psum groups back-to-back from the vector table
    o_ready = 1'b1;
    foreach (vecs[i]) begin
      cfg_len = vecs[i].len; cfg_shift = vecs[i].shift; cfg_relu = vecs[i].relu;
      sb.push_back(vecs[i].exp);
      send(vecs[i].psum);
    end
    drain();

    // Rounding on two-psum groups
    cfg_len = 8'd2; cfg_shift = 5'd2; cfg_relu = 1'b0;
    send(5);  sb.push_back(2);   send(2);
    send(-5); sb.push_back(-2);  send(-2);
    cfg_shift = 5'd0;
    send(7);  sb.push_back(7);   send(0);
    drain();

    // Backpressure: the fifth result finds the FIFO full and is dropped
    o_ready = 1'b0; cfg_len = 8'd1; cfg_shift = 5'd0;
    for (int i = 1; i <= 5; i++) begin
      i_valid = 1'b1;
      i_psum  = 16'(i);
      if (i <= 4) sb.push_back(i);
      tick();
      check("bp_stall", int'(o_stall), stall_exp[i-1]);
    end
    i_valid = 1'b0;
    check("bp_ovf_pre", int'(o_ovf), 0);
    tick();
    check("bp_ovf_set", int'(o_ovf), 1);
    check("bp_stall_full", int'(o_stall), 1);
    check("bp_head_valid", int'(o_valid), 1);
    check("bp_head_data", int'($signed(o_data)), 1);
    tick();
    check("bp_head_hold", int'($signed(o_data)), 1);
    drain();
    check("bp_stall_fall", int'(o_stall), 0);
    check("bp_ovf_sticky", int'(o_ovf), 1);
    check("bp_empty", int'(o_valid), 0);

    // Clear mid-group discards the partial sum and the coincident psum
    cfg_len = 8'd4;
    send(9);
    send(9);
    check("clr_busy_pre", int'(o_busy), 1);
    i_clear = 1'b1;
    send(9);
    i_clear = 1'b0;
    check("clr_busy", int'(o_busy), 0);
    send(1); send(2); send(3); sb.push_back(10); send(4);
    drain();

    // Reset mid-group with a pending FIFO entry discards everything
    o_ready = 1'b0; cfg_len = 8'd1;
    send(42);
    cfg_len = 8'd4;
    send(9);
    send(9);
    check("rst_pre_valid", int'(o_valid), 1);
    rst = 1'b1;
    send(9);
    rst = 1'b0;
    check_reset_outputs("midrst");
    basic_group();

    // Gaps in i_valid and a cfg change mid-group
    o_ready = 1'b1; cfg_len = 8'd3; cfg_shift = 5'd0; cfg_relu = 1'b0;
    send(10);
    tick();
    tick();
    cfg_len = 8'd1;
    send(20);
    check("gap_busy", int'(o_busy), 1);
    tick();
    sb.push_back(60);
    send(30);
    check("gap_busy_done", int'(o_busy), 0);
    sb.push_back(7);
    send(7);
    drain();

    for (int n = 0; n < 5; n++) tick();
    check("sb_final", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
